// File: rtl/alu_pkg.sv
// Shared ALU control codes (also used by the ALU control decoder) and the
// execute-unit state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// cycle, sharing a single 2*WIDTH accumulator and iteration counter.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;
    logic               mode_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;

    // acc = {partial product, multiplier} for MUL, {remainder, quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (!mode_q)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode_q <= 1'b0;
        end else if (kill) begin
            cnt <= '0;
        end else if (start) begin
            cnt    <= CNT_W'(WIDTH);
            mode_q <= div_mode;
            opnd   <= div_mode ? b : a;
            acc    <= {{WIDTH{1'b0}}, (div_mode ? a : b)};
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nxt;
        end
    end

    // Final iteration result is taken combinationally so the caller registers
    // it on the same edge the counter expires.
    assign done = (cnt == CNT_W'(1));
    assign lo   = acc_nxt[WIDTH-1:0];
    assign hi   = acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL/DIV,
// with valid/ready handshakes on both sides and registered results.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             seq_start;
    logic             seq_done;
    logic [WIDTH-1:0] seq_lo;
    logic [WIDTH-1:0] seq_hi;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_err;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready && !kill;
    assign is_mul    = (alu_ctrl == ALU_MUL);
    assign is_div    = (alu_ctrl == ALU_DIV);
    assign seq_start = accept && (is_mul || (is_div && op_b != '0));

    muldiv_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (kill),
        .start    (seq_start),
        .div_mode (is_div),
        .a        (op_a),
        .b        (op_b),
        .done     (seq_done),
        .lo       (seq_lo),
        .hi       (seq_hi)
    );

    // DIV only reaches this path on a zero divisor
    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_err = 1'b0;
        case (alu_ctrl)
            ALU_ADD: sc_lo = op_a + op_b;
            ALU_SUB: sc_lo = op_a - op_b;
            ALU_AND: sc_lo = op_a & op_b;
            ALU_OR:  sc_lo = op_a | op_b;
            ALU_NOR: sc_lo = ~(op_a | op_b);
            ALU_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_MUL: sc_lo = '0;
            ALU_DIV: begin
                sc_lo  = '1;
                sc_hi  = op_a;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (seq_start) begin
                            state     <= is_mul ? MUL : DIV;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res_lo    <= sc_lo;
                            res_hi    <= sc_hi;
                            zero      <= (sc_lo == '0);
                            err       <= sc_err;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (seq_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res_lo    <= seq_lo;
                        res_hi    <= seq_hi;
                        zero      <= (seq_lo == '0);
                        err       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit at WIDTH=8: directed corner cases
// followed by randomized operations checked against an arithmetic model.
module tb_alu_muldiv_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         kill = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_ctrl = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic         zero;
    logic         err;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; lat = cycles from accept to out_valid
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic e, output int lat);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned p;
        int sa = (a >= 128) ? int'(a) - 256 : int'(a);
        int sb = (b >= 128) ? int'(b) - 256 : int'(b);
        lo = '0; hi = '0; e = 1'b0; lat = 1;
        case (c)
            4'b0010: lo = W'((ua + ub) % 256);
            4'b0110: lo = W'((ua + 256 - ub) % 256);
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b1100: lo = ~(a | b);
            4'b0111: lo = (sa < sb) ? 8'd1 : 8'd0;
            4'b0100: begin
                p = ua * ub;
                lo = W'(p % 256);
                hi = W'(p / 256);
                lat = W + 1;
            end
            4'b0101: begin
                if (ub == 0) begin
                    lo = 8'hFF; hi = a; e = 1'b1;
                end else begin
                    lo = W'(ua / ub); hi = W'(ua % ub); lat = W + 1;
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int stall);
        logic [W-1:0] elo, ehi;
        logic         eerr;
        int           lat;
        int           k;
        model(c, a, b, elo, ehi, eerr, lat);
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin step(); k++; end
        chk({tag, "_ready_wait"}, 32'(k < 50), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); alu_ctrl = 4'($urandom);
        k = 0;
        while (!out_valid && k < W + 5) begin
            chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
            step();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(lat - 1));
        chk({tag, "_lo"}, 32'(res_lo), 32'(elo));
        chk({tag, "_hi"}, 32'(res_hi), 32'(ehi));
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        chk({tag, "_zero"}, 32'(zero), 32'(elo == '0));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_lo"}, 32'(res_lo), 32'(elo));
            chk({tag, "_hold_zero"}, 32'(zero), 32'(elo == '0));
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] codes [10];
        logic [3:0] c;
        logic [W-1:0] a, b;
        logic seen_valid;

        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                  4'b1100, 4'b0100, 4'b0101, 4'b1111, 4'b0011};

        // Reset
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lo", 32'(res_lo), 32'd0);
        chk("rst_hi", 32'(res_hi), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("add", 4'b0010, 8'hF0, 8'h20, 0);
        chk("add_lo_const", 32'(res_lo), 32'h10);
        run_op("slt", 4'b0111, 8'hFF, 8'h01, 0);
        chk("slt_lo_const", 32'(res_lo), 32'h01);
        run_op("mul", 4'b0100, 8'd200, 8'd3, 0);
        chk("mul_lo_const", 32'(res_lo), 32'h58);
        chk("mul_hi_const", 32'(res_hi), 32'h02);
        run_op("div", 4'b0101, 8'd100, 8'd7, 0);
        chk("div_lo_const", 32'(res_lo), 32'd14);
        chk("div_hi_const", 32'(res_hi), 32'd2);
        run_op("divz", 4'b0101, 8'h2A, 8'h00, 0);
        run_op("ill", 4'b1111, 8'h12, 8'h34, 0);
        run_op("after_ill", 4'b0001, 8'h12, 8'h34, 0);

        // Backpressure then back-to-back accept in DONE
        run_op("sub_stall", 4'b0110, 8'd5, 8'd5, 4);
        alu_ctrl = 4'b0110; op_a = 8'd9; op_b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b1; out_ready = 1'b0;
        alu_ctrl = 4'b0010; op_a = 8'd3; op_b = 8'd4;
        step();
        chk("b2b_stall_ready", 32'(in_ready), 32'd0);
        chk("b2b_stall_lo", 32'(res_lo), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("b2b_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_lo", 32'(res_lo), 32'd7);
        chk("b2b_zero", 32'(zero), 32'd0);
        step();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Kill mid-MUL
        alu_ctrl = 4'b0100; op_a = 8'd200; op_b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("kill_busy", 32'(in_ready), 32'd0);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_idle_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_valid = 1'b1;
            step();
        end
        chk("kill_no_valid", 32'(seen_valid), 32'd0);
        run_op("post_kill", 4'b0010, 8'd11, 8'd22, 0);

        // Reset mid-DIV
        alu_ctrl = 4'b0101; op_a = 8'd100; op_b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("rstdiv_valid", 32'(out_valid), 32'd0);
        chk("rstdiv_lo", 32'(res_lo), 32'd0);
        chk("rstdiv_hi", 32'(res_hi), 32'd0);
        chk("rstdiv_err", 32'(err), 32'd0);
        chk("rstdiv_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        step();

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            c = codes[$urandom_range(0, 9)];
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_op("rand", c, a, b, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
